pxs_ball_ctrl: RTL
==================

// Module: pxs_ball_ctrl
// PURPOSE
//  Motion controller for the pixel-stream ball overlay. Sniffs frame timing from the
//  26-bit pixel stream, advances the ball position once per N frames during vertical
//  blanking, and bounces the ball off the active-area edges. Drives x_ball/y_ball of the
//  ball overlay stage; the stream itself is not modified or forwarded.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line
//  V_ACTIVE   480  active lines per frame
//  SIZE_BALL  16   ball edge length in pixels; must match the overlay stage
//  STEP_X     2    pixels moved per update on X (1..15)
//  STEP_Y     2    pixels moved per update on Y (1..15)
//  X_INIT     312  x_ball after reset/restart
//  Y_INIT     232  y_ball after reset/restart
//  FRAME_DIV  1    frames per position update (1..255)
// PORTS
//  px_clk    in   1   pixel clock; all logic on rising edge
//  reset     in   1   asynchronous, active-high reset
//  RGBStr_i  in   26  pixel stream; only the `XC and `YC fields are read
//  run       in   1   1 = ball moves; 0 = position frozen
//  restart   in   1   sync pulse: reload X_INIT/Y_INIT, dirs +X/+Y
//  x_ball    out  10  ball X position (0..H_ACTIVE-SIZE_BALL)
//  y_ball    out  10  ball Y position (0..V_ACTIVE-SIZE_BALL)
//  hit_x     out  1   1-cycle pulse: X wall bounce this update
//  hit_y     out  1   1-cycle pulse: Y wall bounce this update
// BEHAVIOUR
//  - Reset: x_ball=X_INIT, y_ball=Y_INIT, dir_x=dir_y=+, div counter=0, hit_x=hit_y=0,
//    state=WAIT, speed steps=STEP_X/STEP_Y.
//  - Frame tick: registered compare XC==0 && YC==V_ACTIVE, edge-detected, so exactly one
//    tick per frame. With the stream showing (0,V_ACTIVE) in cycle T, tick is high in T+1.
//  - FSM WAIT -> UPD_X -> UPD_Y -> WAIT. In WAIT on tick with run=1: if div==FRAME_DIV-1
//    then div<=0, go UPD_X; else div<=div+1. run=0: ticks ignored, div held.
//  - Latency: x_ball/hit_x update on edge ending T+2; y_ball/hit_y on edge ending T+3.
//    Both stable long before line V_ACTIVE+1; never changes during active video.
//  - Arithmetic in 11 bits, MAX_X=H_ACTIVE-SIZE_BALL, MAX_Y=V_ACTIVE-SIZE_BALL.
//    dir + : if x+step >= MAX_X then x<=MAX_X, dir<=-, hit pulse; else x<=x+step.
//    dir - : if x <= step then x<=0, dir<=+, hit pulse; else x<=x-step. Same for Y.
//    Position never leaves [0,MAX]; exact landing on a wall counts as a hit.
//  - hit_x/hit_y are high for exactly one cycle, only in the update cycle of their axis.
//  - restart: highest priority, any state. Next edge: positions/dirs/steps reloaded,
//    div=0, state=WAIT, hits cleared. restart coincident with an update: restart wins.
//  - run falling during UPD_X/UPD_Y: update completes (no half-updated frame).
//  - Async reset mid-update: all state immediately to reset values.
// CONFIGURATION
//  PXS_BALL_SPEEDUP_EN defined: each hit on an axis increments that axis's step by 1,
//  saturating at 15; restart/reset reload STEP_X/STEP_Y. Not defined: steps are
//  constant STEP_X/STEP_Y; no step registers synthesised.
// TESTING
//  1 Reset, run=1, FRAME_DIV=1, 640x480 stream: after 1 frame x=314,y=234, no hits.
//  2 Force x=622 dir + (restart with X_INIT=622), STEP_X=2: next update x=624,
//    hit_x=1 for 1 cycle; following update x=622.
//  3 FRAME_DIV=3: position changes on frames 3,6,9 only; run=0 for 2 frames
//    freezes x/y and div; resume continues count.
//  4 restart asserted in same cycle as UPD_X: x=X_INIT,y=Y_INIT, dirs +, no hit pulse.
//  5 reset asserted during UPD_Y: outputs at reset values without a clock edge.
//  6 PXS_BALL_SPEEDUP_EN: 3 X hits -> step_x=5; 14 hits -> saturates at 15.

Source files
------------

// File: rtl/pxs_ball_ctrl.sv
// Ball motion controller: sniffs frame timing from the pixel stream and moves/bounces the ball once per FRAME_DIV frames.
// Optional PXS_BALL_SPEEDUP_EN: each wall hit increments that axis's step (saturating at 15).
`ifndef XC
`define XC 25:16
`endif
`ifndef YC
`define YC 15:6
`endif

module pxs_ball_ctrl #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SIZE_BALL = 16,
   parameter int STEP_X    = 2,
   parameter int STEP_Y    = 2,
   parameter int X_INIT    = 312,
   parameter int Y_INIT    = 232,
   parameter int FRAME_DIV = 1
) (
   input  logic        px_clk,
   input  logic        reset,
   input  logic [25:0] RGBStr_i,
   input  logic        run,
   input  logic        restart,
   output logic [9:0]  x_ball,
   output logic [9:0]  y_ball,
   output logic        hit_x,
   output logic        hit_y
);

   localparam logic [1:0] S_WAIT  = 2'd0;
   localparam logic [1:0] S_UPD_X = 2'd1;
   localparam logic [1:0] S_UPD_Y = 2'd2;

   localparam logic [10:0] MAX_X   = 11'(H_ACTIVE - SIZE_BALL);
   localparam logic [10:0] MAX_Y   = 11'(V_ACTIVE - SIZE_BALL);
   localparam logic [9:0]  X_START = 10'(X_INIT);
   localparam logic [9:0]  Y_START = 10'(Y_INIT);
   localparam logic [7:0]  DIV_TOP = 8'(FRAME_DIV - 1);

   logic [1:0]  state;
   logic [7:0]  div;
   logic        dir_x, dir_y;          // 0 = moving +, 1 = moving -
   logic        frame_eq, frame_eq_d;
   logic        tick;
   logic [3:0]  step_x, step_y;
   logic [10:0] x_sum, y_sum;
   logic        x_hi, x_lo, y_hi, y_lo;
   logic        unused_rgb;

   assign unused_rgb = ^RGBStr_i[5:0];
   assign tick       = frame_eq & ~frame_eq_d;

   assign x_sum = {1'b0, x_ball} + {7'd0, step_x};
   assign y_sum = {1'b0, y_ball} + {7'd0, step_y};
   assign x_hi  = x_sum >= MAX_X;
   assign y_hi  = y_sum >= MAX_Y;
   assign x_lo  = {1'b0, x_ball} <= {7'd0, step_x};
   assign y_lo  = {1'b0, y_ball} <= {7'd0, step_y};

`ifndef PXS_BALL_SPEEDUP_EN
   assign step_x = 4'(STEP_X);
   assign step_y = 4'(STEP_Y);
`endif

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         state      <= S_WAIT;
         div        <= 8'd0;
         x_ball     <= X_START;
         y_ball     <= Y_START;
         dir_x      <= 1'b0;
         dir_y      <= 1'b0;
         hit_x      <= 1'b0;
         hit_y      <= 1'b0;
         frame_eq   <= 1'b0;
         frame_eq_d <= 1'b0;
`ifdef PXS_BALL_SPEEDUP_EN
         step_x     <= 4'(STEP_X);
         step_y     <= 4'(STEP_Y);
`endif
      end else begin
         frame_eq   <= (RGBStr_i[`XC] == 10'd0) && (RGBStr_i[`YC] == 10'(V_ACTIVE));
         frame_eq_d <= frame_eq;
         hit_x      <= 1'b0;
         hit_y      <= 1'b0;
         if (restart) begin
            state  <= S_WAIT;
            div    <= 8'd0;
            x_ball <= X_START;
            y_ball <= Y_START;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
`ifdef PXS_BALL_SPEEDUP_EN
            step_x <= 4'(STEP_X);
            step_y <= 4'(STEP_Y);
`endif
         end else begin
            case (state)
               S_WAIT: begin
                  if (tick && run) begin
                     if (div == DIV_TOP) begin
                        div   <= 8'd0;
                        state <= S_UPD_X;
                     end else begin
                        div <= div + 8'd1;
                     end
                  end
               end
               S_UPD_X: begin
                  state <= S_UPD_Y;
                  if (!dir_x) begin
                     x_ball <= x_hi ? MAX_X[9:0] : x_sum[9:0];
                     dir_x  <= x_hi;
                     hit_x  <= x_hi;
                  end else begin
                     x_ball <= x_lo ? 10'd0 : x_ball - {6'd0, step_x};
                     dir_x  <= ~x_lo;
                     hit_x  <= x_lo;
                  end
`ifdef PXS_BALL_SPEEDUP_EN
                  if ((dir_x ? x_lo : x_hi) && step_x != 4'd15)
                     step_x <= step_x + 4'd1;
`endif
               end
               S_UPD_Y: begin
                  state <= S_WAIT;
                  if (!dir_y) begin
                     y_ball <= y_hi ? MAX_Y[9:0] : y_sum[9:0];
                     dir_y  <= y_hi;
                     hit_y  <= y_hi;
                  end else begin
                     y_ball <= y_lo ? 10'd0 : y_ball - {6'd0, step_y};
                     dir_y  <= ~y_lo;
                     hit_y  <= y_lo;
                  end
`ifdef PXS_BALL_SPEEDUP_EN
                  if ((dir_y ? y_lo : y_hi) && step_y != 4'd15)
                     step_y <= step_y + 4'd1;
`endif
               end
               default: state <= S_WAIT;
            endcase
         end
      end
   end

endmodule
